// File: rtl/des_cmd_sequencer.sv
// des_cmd_sequencer: expands host operations (load key, encrypt, decrypt,
// clear) into the per-cycle mode code stream of the 3DES control unit.
// Command outputs are registered, so each code appears one cycle after the
// state that produced it; busy/op_ready track the state register directly.
module des_cmd_sequencer #(
  parameter int unsigned KEY_BEATS = 8,
  parameter int unsigned BLK_BEATS = 2,
  parameter int unsigned OUT_BEATS = 8,
  parameter int unsigned WAIT_MAX  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [1:0] op_code,
  output logic       op_ready,
  input  logic       in_avail,
  output logic       in_pop,
  input  logic       out_ready,
  output logic       out_push,
  input  logic       core_done,
  output logic [2:0] mode,
  output logic       busy,
  output logic       err
);

  localparam int unsigned BEAT_W = 4;
  localparam int unsigned WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

  localparam logic [2:0] MODE_IDLE = 3'd0;
  localparam logic [2:0] MODE_KEY  = 3'd1;
  localparam logic [2:0] MODE_BLK  = 3'd2;
  localparam logic [2:0] MODE_ENC  = 3'd3;
  localparam logic [2:0] MODE_DEC  = 3'd4;
  localparam logic [2:0] MODE_CLR  = 3'd5;
  localparam logic [2:0] MODE_OUT  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEY   = 3'd1,
    S_BLK   = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_DRAIN = 3'd5,
    S_CLEAR = 3'd6
  } state_e;

  state_e              state, state_nxt;
  logic [BEAT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [1:0]          op_q;
  logic                beat_inc_c;
  logic                timeout_c;
  logic                accept_c;
  logic [2:0]          mode_nxt;
  logic                in_pop_nxt;
  logic                out_push_nxt;
  logic                err_nxt;

  assign accept_c = op_valid && op_ready;

  // State register, beat/wait counters and latched operation code
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      wait_cnt <= '0;
      op_q     <= 2'd0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept_c) begin
        op_q <= op_code;
      end
    end
  end

  // Next-state logic; terminal beat compare precedes any increment
  always_comb begin
    state_nxt  = state;
    beat_inc_c = 1'b0;
    timeout_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          case (op_code)
            2'd0:       state_nxt = S_KEY;
            2'd1, 2'd2: state_nxt = S_BLK;
            2'd3:       state_nxt = S_CLEAR;
          endcase
        end
      end
      S_KEY: begin
        if (in_avail) begin
          if (beat_cnt == BEAT_W'(KEY_BEATS - 1)) state_nxt = S_IDLE;
          else                                    beat_inc_c = 1'b1;
        end
      end
      S_BLK: begin
        if (in_avail) begin
          if (beat_cnt == BEAT_W'(BLK_BEATS - 1)) state_nxt = S_START;
          else                                    beat_inc_c = 1'b1;
        end
      end
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          state_nxt = S_DRAIN;
        end else if (wait_cnt == WAIT_W'(WAIT_MAX - 1)) begin
          timeout_c = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (beat_cnt == BEAT_W'(OUT_BEATS - 1)) state_nxt = S_IDLE;
          else                                    beat_inc_c = 1'b1;
        end
      end
      S_CLEAR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (state_nxt != state)  beat_cnt_nxt = '0;
    else if (beat_inc_c)     beat_cnt_nxt = beat_cnt + BEAT_W'(1);
    else                     beat_cnt_nxt = beat_cnt;

    if (state_nxt != state)  wait_cnt_nxt = '0;
    else if (state == S_WAIT) wait_cnt_nxt = wait_cnt + WAIT_W'(1);
    else                     wait_cnt_nxt = wait_cnt;
  end

  // Command code and handshake strobes produced by the current state
  always_comb begin
    mode_nxt     = MODE_IDLE;
    in_pop_nxt   = 1'b0;
    out_push_nxt = 1'b0;
    err_nxt      = err;
    case (state)
      S_KEY: begin
        if (in_avail) begin
          mode_nxt   = MODE_KEY;
          in_pop_nxt = 1'b1;
        end
      end
      S_BLK: begin
        if (in_avail) begin
          mode_nxt   = MODE_BLK;
          in_pop_nxt = 1'b1;
        end
      end
      S_START: mode_nxt = (op_q == 2'd1) ? MODE_ENC : MODE_DEC;
      S_DRAIN: begin
        if (out_ready) begin
          mode_nxt     = MODE_OUT;
          out_push_nxt = 1'b1;
        end
      end
      S_CLEAR: mode_nxt = MODE_CLR;
      default: mode_nxt = MODE_IDLE;
    endcase

    if (accept_c && (op_code == 2'd3)) err_nxt = 1'b0;
    else if (timeout_c)                err_nxt = 1'b1;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= MODE_IDLE;
      in_pop   <= 1'b0;
      out_push <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      op_ready <= 1'b1;
    end else begin
      mode     <= mode_nxt;
      in_pop   <= in_pop_nxt;
      out_push <= out_push_nxt;
      busy     <= (state_nxt != S_IDLE);
      err      <= err_nxt;
      op_ready <= (state_nxt == S_IDLE);
    end
  end

endmodule

// File: tb/tb_des_cmd_sequencer.sv
// Testbench for des_cmd_sequencer: directed and randomized operations
// checked cycle by cycle against an operation-level reference model.
module tb_des_cmd_sequencer;

  localparam int unsigned KEY_BEATS = 8;
  localparam int unsigned BLK_BEATS = 2;
  localparam int unsigned OUT_BEATS = 8;
  localparam int unsigned WAIT_MAX  = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic [1:0] op_code;
  logic       op_ready;
  logic       in_avail;
  logic       in_pop;
  logic       out_ready;
  logic       out_push;
  logic       core_done;
  logic [2:0] mode;
  logic       busy;
  logic       err;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic exp_err  = 1'b0;
  int   n_pops   = 0;
  int   n_pushes = 0;

  des_cmd_sequencer #(
    .KEY_BEATS(KEY_BEATS),
    .BLK_BEATS(BLK_BEATS),
    .OUT_BEATS(OUT_BEATS),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_ready (op_ready),
    .in_avail (in_avail),
    .in_pop   (in_pop),
    .out_ready(out_ready),
    .out_push (out_push),
    .core_done(core_done),
    .mode     (mode),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic logic rnd_bit();
    return 1'($urandom_range(1));
  endfunction

  function automatic logic [1:0] rnd_code();
    return 2'($urandom_range(3));
  endfunction

  task automatic chk(input string tag, input string sig, input logic [3:0] obs, input logic [3:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s %s observed=%0d expected=%0d", tag, sig, obs, expv);
    end
  endtask

  // Compare every output against the model's expectation for this cycle
  task automatic expect_out(input string tag, input logic [2:0] m, input logic p,
                            input logic q, input logic b, input logic e);
    chk(tag, "mode",     {1'b0, mode},     {1'b0, m});
    chk(tag, "in_pop",   {3'b0, in_pop},   {3'b0, p});
    chk(tag, "out_push", {3'b0, out_push}, {3'b0, q});
    chk(tag, "busy",     {3'b0, busy},     {3'b0, b});
    chk(tag, "op_ready", {3'b0, op_ready}, {3'b0, ~b});
    chk(tag, "err",      {3'b0, err},      {3'b0, e});
    if (in_pop === 1'b1)   n_pops++;
    if (out_push === 1'b1) n_pushes++;
  endtask

  // Drive one cycle of inputs, then sample on the following falling edge
  task automatic step(input logic av, input logic ordy, input logic dn,
                      input logic ov, input logic [1:0] oc, input logic r);
    in_avail  = av;
    out_ready = ordy;
    core_done = dn;
    op_valid  = ov;
    op_code   = oc;
    rst       = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_check(input string tag);
    step(rnd_bit(), rnd_bit(), rnd_bit(), 1'b0, rnd_code(), 1'b0);
    expect_out({tag, ":idle"}, 3'd0, 1'b0, 1'b0, 1'b0, exp_err);
  endtask

  // One operation: expected stream derived from the input pattern chosen here
  task automatic run_op(input logic [1:0] code, input int stall_pct, input int done_at,
                        input int abort_at, input string tag);
    int       beats;
    int       need;
    int       cyc;
    logic     av;
    logic     ordy;
    logic     dn;
    logic     last;
    logic     timed_out;
    logic     alive;
    logic [2:0] beat_mode;

    alive = 1'b1;
    step(rnd_bit(), rnd_bit(), rnd_bit(), 1'b1, code, 1'b0);
    if (code == 2'd3) exp_err = 1'b0;
    expect_out({tag, ":accept"}, 3'd0, 1'b0, 1'b0, 1'b1, exp_err);

    if (code == 2'd3) begin
      step(rnd_bit(), rnd_bit(), rnd_bit(), rnd_bit(), rnd_code(), 1'b0);
      expect_out({tag, ":clear"}, 3'd5, 1'b0, 1'b0, 1'b0, exp_err);
      alive = 1'b0;
    end

    if (alive) begin
      need      = (code == 2'd0) ? KEY_BEATS : BLK_BEATS;
      beat_mode = (code == 2'd0) ? 3'd1 : 3'd2;
      beats     = 0;
      cyc       = 0;
      while (beats < need) begin
        av = (cyc > 40) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
        step(av, rnd_bit(), rnd_bit(), rnd_bit(), rnd_code(), 1'b0);
        if (av) beats++;
        cyc++;
        last = (code == 2'd0) && (beats == need);
        expect_out({tag, ":shift_in"}, av ? beat_mode : 3'd0, av, 1'b0, ~last, exp_err);
      end
      if (code == 2'd0) alive = 1'b0;
    end

    if (alive) begin
      step(rnd_bit(), rnd_bit(), rnd_bit(), rnd_bit(), rnd_code(), 1'b0);
      expect_out({tag, ":start"}, (code == 2'd1) ? 3'd3 : 3'd4, 1'b0, 1'b0, 1'b1, exp_err);

      timed_out = 1'b1;
      for (int w = 1; w <= int'(WAIT_MAX); w++) begin
        dn = (w == done_at);
        step(rnd_bit(), rnd_bit(), dn, 1'b1, rnd_code(), 1'b0);
        if (!dn && w == int'(WAIT_MAX)) exp_err = 1'b1;
        expect_out({tag, ":wait"}, 3'd0, 1'b0, 1'b0, 1'b1, exp_err);
        if (dn) begin
          timed_out = 1'b0;
          break;
        end
      end

      if (timed_out) begin
        step(rnd_bit(), rnd_bit(), rnd_bit(), rnd_bit(), rnd_code(), 1'b0);
        expect_out({tag, ":timeout_clear"}, 3'd5, 1'b0, 1'b0, 1'b0, exp_err);
        alive = 1'b0;
      end
    end

    if (alive) begin
      beats = 0;
      cyc   = 0;
      while (alive && beats < int'(OUT_BEATS)) begin
        if (abort_at > 0 && beats == abort_at) begin
          step(rnd_bit(), 1'b1, rnd_bit(), rnd_bit(), rnd_code(), 1'b1);
          exp_err = 1'b0;
          expect_out({tag, ":reset"}, 3'd0, 1'b0, 1'b0, 1'b0, exp_err);
          alive = 1'b0;
        end else begin
          ordy = (cyc > 40) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
          step(rnd_bit(), ordy, rnd_bit(), rnd_bit(), rnd_code(), 1'b0);
          if (ordy) beats++;
          cyc++;
          last = (beats == int'(OUT_BEATS));
          expect_out({tag, ":drain"}, ordy ? 3'd6 : 3'd0, 1'b0, ordy, ~last, exp_err);
        end
      end
    end

    idle_check(tag);
  endtask

  initial begin
    int p0;
    int q0;
    int pct;
    int dly;

    rst       = 1'b1;
    op_valid  = 1'b0;
    op_code   = 2'd0;
    in_avail  = 1'b0;
    out_ready = 1'b0;
    core_done = 1'b0;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1);
    expect_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_check("post_reset");

    p0 = n_pops;
    run_op(2'd0, 0, 0, 0, "key_nostall");
    chk("key_nostall", "pop_total", 4'(n_pops - p0), 4'(KEY_BEATS));

    p0 = n_pops;
    q0 = n_pushes;
    run_op(2'd1, 0, 5, 0, "enc_done5");
    chk("enc_done5", "pop_total", 4'(n_pops - p0), 4'(BLK_BEATS));
    chk("enc_done5", "push_total", 4'(n_pushes - q0), 4'(OUT_BEATS));

    p0 = n_pops;
    q0 = n_pushes;
    run_op(2'd2, 45, 1, 0, "dec_stall_done1");
    chk("dec_stall_done1", "pop_total", 4'(n_pops - p0), 4'(BLK_BEATS));
    chk("dec_stall_done1", "push_total", 4'(n_pushes - q0), 4'(OUT_BEATS));

    run_op(2'd1, 30, WAIT_MAX, 0, "enc_done_last");
    run_op(2'd1, 20, 0, 0, "enc_timeout");
    run_op(2'd0, 30, 0, 0, "key_err_held");
    run_op(2'd3, 0, 0, 0, "clear_err");

    q0 = n_pushes;
    run_op(2'd2, 0, 3, 3, "dec_reset_drain");
    idle_check("after_reset");
    chk("dec_reset_drain", "push_total", 4'(n_pushes - q0), 4'd3);

    for (int i = 0; i < 12; i++) begin
      pct = int'($urandom_range(50));
      dly = ($urandom_range(4) == 0) ? 0 : int'($urandom_range(1, WAIT_MAX));
      run_op(rnd_code(), pct, dly, 0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
